// File: rtl/cache_controller_param.sv
// Parametrised two-way set-associative read cache between the MEM stage and the SRAM controller.
// Reads that hit complete combinationally in the request cycle. Misses fill a whole line from
// SRAM into the LRU victim way. Stores are write-through and update a hitting line in place.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   rdEn, wrEn, address, writeData  requester side (held until ready)
//   readData, ready                 load data (0 unless ready && rdEn), completion strobe
//   sramReady, sramReadData         SRAM completion strobe and full fill line
//   sramRdEn, sramWrEn              SRAM line-fill / write-through requests
//   hitCount, missCount             saturating read hit / miss counters
module cache_controller_param #(
  parameter int unsigned INDEX_W    = 6,
  parameter int unsigned LINE_WORDS = 2,
  parameter int unsigned ADDR_W     = 19,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdEn,
  input  logic                      wrEn,
  input  logic [31:0]               address,
  input  logic [31:0]               writeData,
  output logic [31:0]               readData,
  output logic                      ready,
  input  logic                      sramReady,
  input  logic [32*LINE_WORDS-1:0]  sramReadData,
  output logic                      sramRdEn,
  output logic                      sramWrEn,
  output logic [CNT_W-1:0]          hitCount,
  output logic [CNT_W-1:0]          missCount
);

  localparam int unsigned WSEL_W  = $clog2(LINE_WORDS);
  localparam int unsigned TAG_W   = ADDR_W - INDEX_W - WSEL_W - 2;
  localparam int unsigned SETS    = 2 ** INDEX_W;
  localparam int unsigned IDX_LSB = WSEL_W + 2;
  localparam int unsigned TAG_LSB = IDX_LSB + INDEX_W;

  typedef enum logic [1:0] {StIdle, StFill, StWrite} state_e;

  state_e state_q, state_d;

  logic [1:0]        valid_q [SETS];           // bit w = way w valid
  logic [SETS-1:0]   lru_q;                    // victim way per set
  logic [TAG_W-1:0]  tag_q   [2][SETS];
  logic [31:0]       data_q  [2][SETS][LINE_WORDS];
  logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  // Address decode
  logic [WSEL_W-1:0]  word_sel;
  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tag;
  logic               unused_addr;

  assign word_sel    = address[IDX_LSB-1:2];
  assign idx         = address[TAG_LSB-1:IDX_LSB];
  assign tag         = address[ADDR_W-1:TAG_LSB];
  assign unused_addr = ^{address[31:ADDR_W], address[1:0]};

  logic [31:0] line_words [LINE_WORDS];
  always_comb begin
    for (int k = 0; k < LINE_WORDS; k++) begin
      line_words[k] = sramReadData[32*k +: 32];
    end
  end

  // Tags are unique within a set, so at most one way hits and way1's match names the way.
  logic hit0, hit1, hit, hit_way, victim;
  assign hit0    = valid_q[idx][0] && (tag_q[0][idx] == tag);
  assign hit1    = valid_q[idx][1] && (tag_q[1][idx] == tag);
  assign hit     = hit0 | hit1;
  assign hit_way = hit1;
  assign victim  = lru_q[idx];

  logic [31:0] rdata;
  logic        fill_en, wr_en, lru_en, lru_val, hit_inc, miss_inc;

  always_comb begin
    state_d  = state_q;
    ready    = 1'b0;
    rdata    = '0;
    sramRdEn = 1'b0;
    sramWrEn = 1'b0;
    fill_en  = 1'b0;
    wr_en    = 1'b0;
    lru_en   = 1'b0;
    lru_val  = 1'b0;
    hit_inc  = 1'b0;
    miss_inc = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (wrEn) begin
          state_d = StWrite;
        end else if (rdEn) begin
          if (hit) begin
            ready   = 1'b1;
            rdata   = data_q[hit_way][idx][word_sel];
            lru_en  = 1'b1;
            lru_val = ~hit_way;
            hit_inc = 1'b1;
          end else begin
            state_d = StFill;
          end
        end
      end
      StFill: begin
        sramRdEn = 1'b1;
        if (sramReady) begin
          ready    = 1'b1;
          rdata    = line_words[word_sel];
          fill_en  = 1'b1;
          lru_en   = 1'b1;
          lru_val  = ~victim;
          miss_inc = 1'b1;
          state_d  = StIdle;
        end
      end
      StWrite: begin
        sramWrEn = 1'b1;
        if (sramReady) begin
          ready = 1'b1;
          if (hit) begin
            wr_en   = 1'b1;
            lru_en  = 1'b1;
            lru_val = ~hit_way;
          end
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (rst) begin
      ready    = 1'b0;
      sramRdEn = 1'b0;
      sramWrEn = 1'b0;
    end
    readData = (ready && rdEn) ? rdata : 32'h0;
  end

  // Saturating counters
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (hit_inc && (hit_cnt_q != '1)) hit_cnt_d = hit_cnt_q + CNT_W'(1);
    if (miss_inc && (miss_cnt_q != '1)) miss_cnt_d = miss_cnt_q + CNT_W'(1);
  end

  assign hitCount  = hit_cnt_q;
  assign missCount = miss_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      lru_q      <= '0;
      for (int s = 0; s < SETS; s++) valid_q[s] <= 2'b00;
    end else begin
      state_q    <= state_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      if (lru_en) lru_q[idx] <= lru_val;
      if (fill_en) valid_q[idx][victim] <= 1'b1;
    end
  end

  // Tag/data contents need no reset; valid bits qualify them.
  always_ff @(posedge clk) begin
    if (!rst && fill_en) begin
      tag_q[victim][idx] <= tag;
      for (int k = 0; k < LINE_WORDS; k++) data_q[victim][idx][k] <= line_words[k];
    end
    if (!rst && wr_en) data_q[hit_way][idx][word_sel] <= writeData;
  end

endmodule

// File: tb/tb_cache_controller_param.sv
module tb_cache_controller_param;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // DUT A: default parameters
  logic        a_rd = 0, a_wr = 0, a_srdy = 0;
  logic [31:0] a_addr = 0, a_wdata = 0;
  logic [63:0] a_line = 0;
  logic [31:0] a_rdata;
  logic        a_ready, a_srd, a_swr;
  logic [15:0] a_hc, a_mc;

  cache_controller_param dut_a (
    .clk(clk), .rst(rst), .rdEn(a_rd), .wrEn(a_wr), .address(a_addr), .writeData(a_wdata),
    .readData(a_rdata), .ready(a_ready), .sramReady(a_srdy), .sramReadData(a_line),
    .sramRdEn(a_srd), .sramWrEn(a_swr), .hitCount(a_hc), .missCount(a_mc)
  );

  // DUT B: 4-word lines, 16 sets, 2-bit counters
  logic         b_rd = 0, b_wr = 0, b_srdy = 0;
  logic [31:0]  b_addr = 0, b_wdata = 0;
  logic [127:0] b_line = 0;
  logic [31:0]  b_rdata;
  logic         b_ready, b_srd, b_swr;
  logic [1:0]   b_hc, b_mc;

  cache_controller_param #(.INDEX_W(4), .LINE_WORDS(4), .ADDR_W(19), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .rdEn(b_rd), .wrEn(b_wr), .address(b_addr), .writeData(b_wdata),
    .readData(b_rdata), .ready(b_ready), .sramReady(b_srdy), .sramReadData(b_line),
    .sramRdEn(b_srd), .sramWrEn(b_swr), .hitCount(b_hc), .missCount(b_mc)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    a_rd = 0; a_wr = 0; a_srdy = 0;
    b_rd = 0; b_wr = 0; b_srdy = 0;
    step();
    step();
    rst = 1'b0;
  endtask

  // One request on DUT A: lat wait cycles in FILL/WRITE before sramReady.
  // junk drives sramReady during the IDLE cycle, where it must be ignored.
  task automatic run_txn(input bit is_wr, input bit both, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [63:0] line, input int lat,
                         input bit exp_hit, input logic [31:0] exp_data, input bit junk);
    a_addr = addr; a_wdata = wdata; a_line = line;
    a_wr = is_wr; a_rd = !is_wr || both; a_srdy = junk;
    #1;
    if (is_wr) begin
      check("wr_req_ready", 64'(a_ready), 64'(0));
      check("wr_req_srd", 64'(a_srd), 64'(0));
      step();
      for (int i = 0; i < lat; i++) begin
        a_srdy = 0;
        #1;
        check("wr_wait_swr", 64'(a_swr), 64'(1));
        check("wr_wait_ready", 64'(a_ready), 64'(0));
        check("wr_wait_srd", 64'(a_srd), 64'(0));
        step();
      end
      a_srdy = 1;
      #1;
      check("wr_done_ready", 64'(a_ready), 64'(1));
      check("wr_done_swr", 64'(a_swr), 64'(1));
      check("wr_done_srd", 64'(a_srd), 64'(0));
      step();
    end else if (exp_hit) begin
      check("hit_ready", 64'(a_ready), 64'(1));
      check("hit_data", 64'(a_rdata), 64'(exp_data));
      check("hit_srd", 64'(a_srd), 64'(0));
      step();
    end else begin
      check("miss_req_ready", 64'(a_ready), 64'(0));
      check("miss_req_data", 64'(a_rdata), 64'(0));
      check("miss_req_srd", 64'(a_srd), 64'(0));
      step();
      for (int i = 0; i < lat; i++) begin
        a_srdy = 0;
        #1;
        check("fill_wait_srd", 64'(a_srd), 64'(1));
        check("fill_wait_ready", 64'(a_ready), 64'(0));
        step();
      end
      a_srdy = 1;
      #1;
      check("fill_done_ready", 64'(a_ready), 64'(1));
      check("fill_done_data", 64'(a_rdata), 64'(exp_data));
      check("fill_done_swr", 64'(a_swr), 64'(0));
      step();
    end
    a_rd = 0; a_wr = 0; a_srdy = 0;
  endtask

  // Directed vectors
  typedef struct {
    bit          is_wr;
    bit          both;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [63:0] line;
    bit          exp_hit;
    logic [31:0] exp_data;
    int          exp_hc;
    int          exp_mc;
  } vec_t;

  vec_t vecs[16];

  // Reference model: cache is transparent over a word memory; each set keeps a recency
  // list of up to two line tags (most recent first).
  logic [31:0] mem [int unsigned];
  int unsigned m_mru [64];
  int unsigned m_oth [64];
  int          m_n   [64];
  int          m_hc, m_mc;

  function automatic logic [31:0] mem_rd(input int unsigned wa);
    if (mem.exists(wa)) return mem[wa];
    return (wa * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic bit m_lookup(input int unsigned s, input int unsigned t);
    return (m_n[s] >= 1 && m_mru[s] == t) || (m_n[s] == 2 && m_oth[s] == t);
  endfunction

  task automatic m_touch(input int unsigned s, input int unsigned t);
    if (m_n[s] == 2 && m_oth[s] == t) begin
      m_oth[s] = m_mru[s];
      m_mru[s] = t;
    end
  endtask

  task automatic m_insert(input int unsigned s, input int unsigned t);
    if (m_n[s] >= 1) m_oth[s] = m_mru[s];
    m_mru[s] = t;
    if (m_n[s] < 2) m_n[s]++;
  endtask

  initial begin
    vecs[0]  = '{0, 0, 32'h100, 32'h0, 64'hBBBBBBBB_AAAAAAAA, 0, 32'hAAAAAAAA, 0, 1};
    vecs[1]  = '{0, 0, 32'h104, 32'h0, 64'h0, 1, 32'hBBBBBBBB, 1, 1};
    vecs[2]  = '{0, 0, 32'h000, 32'h0, 64'h11110001_11110000, 0, 32'h11110000, 1, 2};
    vecs[3]  = '{0, 0, 32'h200, 32'h0, 64'h22220001_22220000, 0, 32'h22220000, 1, 3};
    vecs[4]  = '{0, 0, 32'h000, 32'h0, 64'h0, 1, 32'h11110000, 2, 3};
    vecs[5]  = '{0, 0, 32'h400, 32'h0, 64'h44440001_44440000, 0, 32'h44440000, 2, 4};
    vecs[6]  = '{0, 0, 32'h004, 32'h0, 64'h0, 1, 32'h11110001, 3, 4};
    vecs[7]  = '{0, 0, 32'h200, 32'h0, 64'h22221001_22221000, 0, 32'h22221000, 3, 5};
    vecs[8]  = '{1, 0, 32'h104, 32'hDEADBEEF, 64'h0, 0, 32'h0, 3, 5};
    vecs[9]  = '{0, 0, 32'h104, 32'h0, 64'h0, 1, 32'hDEADBEEF, 4, 5};
    vecs[10] = '{1, 0, 32'h800, 32'h12345678, 64'h0, 0, 32'h0, 4, 5};
    vecs[11] = '{0, 0, 32'h800, 32'h0, 64'h88880001_88880000, 0, 32'h88880000, 4, 6};
    vecs[12] = '{1, 1, 32'h100, 32'hCAFEF00D, 64'h0, 0, 32'h0, 4, 6};
    vecs[13] = '{0, 0, 32'h100, 32'h0, 64'h0, 1, 32'hCAFEF00D, 5, 6};
    vecs[14] = '{0, 0, 32'h204, 32'h0, 64'h0, 1, 32'h22221001, 6, 6};
    vecs[15] = '{0, 0, 32'h000, 32'h0, 64'h11112001_11112000, 0, 32'h11112000, 6, 7};

    step();
    do_reset();
    #1;
    check("rst_ready", 64'(a_ready), 64'(0));
    check("rst_rdata", 64'(a_rdata), 64'(0));
    check("rst_srd", 64'(a_srd), 64'(0));
    check("rst_swr", 64'(a_swr), 64'(0));
    check("rst_hc", 64'(a_hc), 64'(0));
    check("rst_mc", 64'(a_mc), 64'(0));

    for (int i = 0; i < 16; i++) begin
      run_txn(vecs[i].is_wr, vecs[i].both, vecs[i].addr, vecs[i].wdata, vecs[i].line, i % 3,
              vecs[i].exp_hit, vecs[i].exp_data, 1'(i % 2));
      check($sformatf("vec%0d_hit_cnt", i), 64'(a_hc), 64'(vecs[i].exp_hc));
      check($sformatf("vec%0d_miss_cnt", i), 64'(a_mc), 64'(vecs[i].exp_mc));
    end

    // Reset during FILL aborts the fill
    a_rd = 1; a_addr = 32'h300; a_srdy = 0;
    step();
    #1;
    check("midfill_srd", 64'(a_srd), 64'(1));
    rst = 1; a_srdy = 1; a_line = 64'hFFFF0001_FFFF0000;
    #1;
    check("rstfill_ready", 64'(a_ready), 64'(0));
    check("rstfill_srd", 64'(a_srd), 64'(0));
    check("rstfill_rdata", 64'(a_rdata), 64'(0));
    step();
    rst = 0; a_rd = 0; a_srdy = 0;
    #1;
    check("postrst_srd", 64'(a_srd), 64'(0));
    check("postrst_swr", 64'(a_swr), 64'(0));
    check("postrst_hc", 64'(a_hc), 64'(0));
    check("postrst_mc", 64'(a_mc), 64'(0));
    run_txn(0, 0, 32'h104, 32'h0, 64'h55550001_55550000, 1, 0, 32'h55550001, 0);
    check("postrst_miss_cnt", 64'(a_mc), 64'(1));
    run_txn(0, 0, 32'h300, 32'h0, 64'h66660001_66660000, 0, 0, 32'h66660000, 0);
    check("postrst_miss_cnt2", 64'(a_mc), 64'(2));

    // Randomized phase against the reference model
    do_reset();
    for (int s = 0; s < 64; s++) m_n[s] = 0;
    m_hc = 0; m_mc = 0;
    for (int n = 0; n < 400; n++) begin
      int unsigned s, t, w, wa, kind;
      logic [31:0] addr, wdata;
      bit hit;
      s = $urandom_range(0, 2);
      t = $urandom_range(0, 3);
      w = $urandom_range(0, 1);
      addr = ($urandom & 32'hFFF8_0003) | (t << 9) | (s << 3) | (w << 2);
      wa = (t << 7) | (s << 1) | w;
      kind = $urandom_range(0, 9);
      if (kind < 3) begin
        wdata = $urandom;
        run_txn(1, kind == 0, addr, wdata, 64'h0, $urandom_range(0, 3), 0, 32'h0,
                1'($urandom_range(0, 1)));
        mem[wa] = wdata;
        if (m_lookup(s, t)) m_touch(s, t);
      end else begin
        hit = m_lookup(s, t);
        run_txn(0, 0, addr, 32'h0, {mem_rd(wa | 1), mem_rd(wa & ~32'd1)},
                $urandom_range(0, 3), hit, mem_rd(wa), 1'($urandom_range(0, 1)));
        if (hit) begin
          m_touch(s, t);
          m_hc++;
        end else begin
          m_insert(s, t);
          m_mc++;
        end
      end
      check("rand_hit_cnt", 64'(a_hc), 64'(m_hc));
      check("rand_miss_cnt", 64'(a_mc), 64'(m_mc));
    end

    // DUT B: word 3 of a 4-word fill, then saturating 2-bit hit counter
    do_reset();
    b_rd = 1; b_addr = 32'h0000_000C;
    #1;
    check("b_miss_ready", 64'(b_ready), 64'(0));
    step();
    b_line = 128'h33333333_22222222_11111111_00000000;
    b_srdy = 1;
    #1;
    check("b_fill_srd", 64'(b_srd), 64'(1));
    check("b_fill_ready", 64'(b_ready), 64'(1));
    check("b_fill_word3", 64'(b_rdata), 64'(32'h33333333));
    step();
    b_srdy = 0;
    check("b_miss_cnt", 64'(b_mc), 64'(1));
    for (int n = 1; n <= 5; n++) begin
      b_addr = (n % 2 == 1) ? 32'h0000_0008 : 32'h0000_000C;
      #1;
      check("b_hit_ready", 64'(b_ready), 64'(1));
      check("b_hit_data", 64'(b_rdata), (n % 2 == 1) ? 64'(32'h22222222) : 64'(32'h33333333));
      step();
      check($sformatf("b_hit_cnt%0d", n), 64'(b_hc), 64'((n > 3) ? 3 : n));
    end
    b_rd = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cache_controller_param.md
# cache_controller_param

Parametrised two-way set-associative read cache sitting between the MEM stage and the SRAM controller, successor to the fixed 64-set, 2-word-line controller. Set count, line length and tag width are parameters. Write-through stores update a hitting line in place instead of invalidating it. An explicit miss/write state machine drives the SRAM handshake, and saturating hit/miss counters are exposed for performance measurement.

## Interface
- INDEX_W, 6, set-index bits; set count = 2^INDEX_W
- LINE_WORDS, 2, 32-bit words per line; power of two ≥2; WSEL_W = log2(LINE_WORDS)
- ADDR_W, 19, byte-address bits decoded; TAG_W = ADDR_W − INDEX_W − WSEL_W − 2 (must be ≥1)
- CNT_W, 16, width of the performance counters
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- rdEn  in  1  read request; held with address until ready
- wrEn  in  1  write request; held with address/writeData until ready
- address  in  32  byte address; bits [1:0] ignored; word = [WSEL_W+1:2], index = next INDEX_W bits, tag = next TAG_W bits; bits above ADDR_W ignored
- writeData  in  32  store data
- readData  out  32  load data; valid only while ready && rdEn; 0 otherwise
- ready  out  1  request completes this cycle
- sramReady  in  1  SRAM controller completion strobe
- sramReadData  in  32*LINE_WORDS  full line; word k at bits [32k+31:32k]
- sramRdEn  out  1  line-fill request
- sramWrEn  out  1  write-through request
- hitCount  out  CNT_W  saturating read-hit counter
- missCount  out  CNT_W  saturating read-miss counter

## Operation
- Storage per set: two ways, each with valid bit, TAG_W tag, LINE_WORDS data words; one LRU bit per set naming the victim way (0 → way0).
- Hit = valid && tag match in either way; both ways never hold the same tag.
- States: IDLE, FILL, WRITE.
- IDLE, wrEn=1 → WRITE (wrEn has priority when rdEn=1 simultaneously).
- IDLE, rdEn=1, hit → ready=1, readData = addressed word of hitting way; LRU ← other way; hitCount+1; stay IDLE.
- IDLE, rdEn=1, miss → FILL; no output change this cycle.
- FILL: sramRdEn=1. On sramReady: ready=1, readData = selected word of sramReadData; at the edge, victim way (per LRU) ← line, tag, valid=1; LRU ← other way; missCount+1; → IDLE.
- WRITE: sramWrEn=1. On sramReady: ready=1; if address hits, the addressed word of the hitting way ← writeData and LRU ← other way; a miss allocates nothing; → IDLE.
- Hit detection in FILL/WRITE uses the arrays as held; requests are not re-evaluated outside IDLE.
- Counters saturate at 2^CNT_W−1; they do not wrap.
- rst=1 at an edge: state ← IDLE; all valid bits, LRU bits and counters ← 0; tag/data contents are don't-care. While rst=1, ready, sramRdEn and sramWrEn are forced 0 combinationally.

## Timing
- Reset values: ready=0, readData=0, sramRdEn=0, sramWrEn=0, hitCount=0, missCount=0.
- Read hit: ready in the same cycle rdEn is first sampled in IDLE (0-cycle latency).
- Read miss: sramRdEn rises the cycle after the request; ready coincides with sramReady; minimum 1 cycle plus SRAM latency.
- Write: sramWrEn rises the cycle after the request; ready coincides with sramReady.
- The requester must drop rdEn/wrEn or present a new request the cycle after ready; a still-asserted request is treated as new (a repeated read of a just-filled line is a hit).
- sramReady outside FILL/WRITE is ignored.
- Reset asserted in FILL/WRITE aborts the access; no array update and no counter increment occur at that edge.

## Test plan
- After reset, read 0x0000_0100 → FILL, sramRdEn=1; sramReady with line {0xBBBB_BBBB,0xAAAA_AAAA} → readData=0xAAAA_AAAA, ready=1, missCount=1; re-read 0x104 → 0-cycle hit, 0xBBBB_BBBB, hitCount=1.
- Fill tags 0 and 1 into index 0 (addresses 0x000, 0x200), read 0x000, then read 0x400 → way holding 0x200 evicted; subsequent 0x000 hits, 0x200 misses.
- Write 0xDEAD_BEEF to a cached 0x104 → sramWrEn until sramReady, ready=1; read 0x104 → hit returning 0xDEAD_BEEF with no SRAM access. Write to an uncached address → no allocation; next read misses.
- rdEn and wrEn together in IDLE → WRITE entered, sramRdEn stays 0.
- Assert rst mid-FILL before sramReady → next cycle IDLE, sramRdEn=0, all reads miss, counters 0.
- With CNT_W=2, perform 5 read hits → hitCount holds at 3. With LINE_WORDS=4, INDEX_W=4, word 3 of a fill returns sramReadData[127:96].
